// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//
// Plays a queue of (period, duration) notes as a square wave. The host pushes
// notes into a small FIFO; the sequencer pops one note at a time and plays it.
// Each note starts with a single LOAD cycle. The period counter and the tick
// prescaler run by themselves and are cleared between notes, so the host never
// has to pulse a reset to start the next note.
//
// Optional build macro:
//   TONE_SEQ_STOP_EN - adds the 'stop' input. stop==1 at a clock edge empties
//                      the FIFO and returns the player to IDLE, exactly like
//                      reset. note_ready is not gated by stop, but any push on
//                      that edge is discarded. reset has priority over stop.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   note_valid   in   host presents a note
//   note_period  in   half-period in clocks (0 = rest)
//   note_dur     in   note length in ticks of TICK_DIV clocks (0 = skip)
//   stop         in   abort playback and flush (TONE_SEQ_STOP_EN only)
//   note_ready   out  FIFO can accept a note
//   tone_out     out  square-wave audio output
//   count        out  current period-counter value
//   busy         out  high while in LOAD or PLAY
//   fifo_level   out  number of queued notes
//   o_dbg_state  out  FSM state (0 = IDLE, 1 = LOAD, 2 = PLAY)
//
// Handshake: a note is transferred on every rising clk edge where
// note_valid && note_ready. note_ready depends only on the registered FIFO
// level and the reset input, never on note_valid. When the FIFO is full,
// note_ready stays low even in a cycle where a pop frees a slot.
// -----------------------------------------------------------------------------
module tone_sequencer #(
  parameter int PERIOD_W = 8,
  parameter int DUR_W    = 8,
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      note_valid,
  input  logic [PERIOD_W-1:0]       note_period,
  input  logic [DUR_W-1:0]          note_dur,
`ifdef TONE_SEQ_STOP_EN
  input  logic                      stop,
`endif
  output logic                      note_ready,
  output logic                      tone_out,
  output logic [PERIOD_W-1:0]       count,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [1:0]                o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_mem_period [DEPTH];
  logic [DUR_W-1:0]    r_mem_dur    [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_count;
  logic [DUR_W-1:0]    r_dur;
  logic [PW-1:0]       r_presc;
  logic                r_tone;

  logic                w_stop;
  logic                w_push;
  logic                w_pop;
  logic                w_tick;
  logic                w_note_end;
  logic [LW-1:0]       w_level_nxt;
  logic [PERIOD_W-1:0] w_head_period;
  logic [DUR_W-1:0]    w_head_dur;

`ifdef TONE_SEQ_STOP_EN
  assign w_stop = stop;
`else
  assign w_stop = 1'b0;
`endif

  assign note_ready  = reset && (r_level < LW'(DEPTH));
  assign w_push      = note_valid && note_ready;
  assign w_pop       = (r_state == S_LOAD) && (r_level != '0);
  // The level after this edge. A push on the same edge counts, so the next
  // note follows without an extra IDLE cycle.
  assign w_level_nxt = r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  assign w_head_period = r_mem_period[r_rd_ptr];
  assign w_head_dur    = r_mem_dur[r_rd_ptr];

  assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
  assign w_note_end = w_tick && (r_dur == DUR_W'(1));

  // The FIFO storage has no reset. Pointers and level alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_period[r_wr_ptr] <= note_period;
      r_mem_dur[r_wr_ptr]    <= note_dur;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || w_stop) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_period <= '0;
      r_dur    <= '0;
      r_count  <= '0;
      r_presc  <= '0;
      r_tone   <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          r_presc <= '0;
          r_tone  <= 1'b0;
          if (r_level != '0) r_state <= S_LOAD;
        end

        S_LOAD: begin
          r_period <= w_head_period;
          r_dur    <= w_head_dur;
          r_count  <= '0;
          r_presc  <= '0;
          r_tone   <= 1'b0;
          // A zero-length note is dropped here and never enters PLAY.
          if (w_head_dur == '0)
            r_state <= (w_level_nxt != '0) ? S_LOAD : S_IDLE;
          else
            r_state <= S_PLAY;
        end

        S_PLAY: begin
          r_presc <= w_tick ? '0 : r_presc + PW'(1);
          if (w_tick) r_dur <= r_dur - DUR_W'(1);

          if (w_note_end) begin
            r_count <= '0;
            r_tone  <= 1'b0;
            r_state <= (w_level_nxt != '0) ? S_LOAD : S_IDLE;
          end else if (r_period == '0) begin
            // Rest: the waveform stays silent for the whole duration.
            r_count <= '0;
            r_tone  <= 1'b0;
          end else if (r_count == r_period - PERIOD_W'(1)) begin
            r_count <= '0;
            r_tone  <= ~r_tone;
          end else begin
            r_count <= r_count + PERIOD_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tone_out    = r_tone;
  assign count       = r_count;
  assign busy        = (r_state != S_IDLE);
  assign fifo_level  = r_level;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

  localparam int PW = 8;
  localparam int DW = 8;
  localparam int DP = 4;
  localparam int TD = 4;
  localparam int NW = PW + DW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          note_valid = 1'b0;
  logic [PW-1:0] note_period = '0;
  logic [DW-1:0] note_dur = '0;
`ifdef TONE_SEQ_STOP_EN
  logic          stop = 1'b0;
`endif
  logic          note_ready;
  logic          tone_out;
  logic [PW-1:0] count;
  logic          busy;
  logic [$clog2(DP):0] fifo_level;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  tone_sequencer #(
    .PERIOD_W(PW),
    .DUR_W(DW),
    .DEPTH(DP),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .note_valid(note_valid),
    .note_period(note_period),
    .note_dur(note_dur),
`ifdef TONE_SEQ_STOP_EN
    .stop(stop),
`endif
    .note_ready(note_ready),
    .tone_out(tone_out),
    .count(count),
    .busy(busy),
    .fifo_level(fifo_level),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [NW-1:0] exp_q[$];   // accepted notes, {period, dur}, oldest first
  bit  mon_en      = 1'b0;
  bit  abort       = 1'b0;   // set right after a reset/stop edge has flushed everything
  int  mon_left    = 0;      // PLAY cycles still expected for the current note
  int  mon_k       = 0;      // PLAY cycle index within the current note
  int  mon_period  = 0;
  bit  prev_active = 1'b0;   // previous monitored cycle was LOAD or the end of a note
  int  idle_wait   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  // The reference waveform is computed directly from the note: in PLAY cycle k
  // of a note with half-period P, count = k mod P and tone = floor(k/P) mod 2.
  always @(negedge clk) begin
    int lvl;
    logic [NW-1:0] note;
    if (mon_en) begin
      lvl = exp_q.size();
      chk("note_ready", note_ready, (reset && (lvl < DP)) ? 1 : 0);
      if (abort) begin
        chk("abort_tone", tone_out, 0);
        chk("abort_count", count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_level", fifo_level, 0);
        chk("abort_state", dbg_state, ST_IDLE);
        abort       = 1'b0;
        mon_left    = 0;
        prev_active = 1'b0;
        idle_wait   = 0;
      end else if (mon_left > 0) begin
        chk("play_state", dbg_state, ST_PLAY);
        chk("play_busy", busy, 1);
        chk("play_level", fifo_level, lvl);
        chk("play_tone", tone_out, (mon_period == 0) ? 0 : (mon_k / mon_period) % 2);
        chk("play_count", count, (mon_period == 0) ? 0 : mon_k % mon_period);
        mon_k++;
        mon_left--;
        prev_active = 1'b1;
      end else begin
        chk("gap_level", fifo_level, lvl);
        chk("gap_tone", tone_out, 0);
        chk("gap_count", count, 0);
        if (dbg_state == ST_LOAD) begin
          chk("load_busy", busy, 1);
          if (lvl == 0) begin
            chk("load_empty", dbg_state, ST_IDLE);
          end else begin
            note       = exp_q.pop_front();
            mon_period = int'(note[NW-1:DW]);
            mon_left   = int'(note[DW-1:0]) * TD;
            mon_k      = 0;
          end
          prev_active = 1'b1;
          idle_wait   = 0;
        end else begin
          chk("idle_state", dbg_state, ST_IDLE);
          chk("idle_busy", busy, 0);
          if (lvl > 0) begin
            idle_wait++;
            if (prev_active) chk("next_load", dbg_state, ST_LOAD);
            else if (idle_wait > 1) chk("idle_stall", dbg_state, ST_LOAD);
          end else begin
            idle_wait = 0;
          end
          prev_active = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the accepting edge with
  // note_valid still high so notes can be issued back to back.
  task automatic push_note(input int p, input int d);
    bit acc;
    int c;
    c = 0;
    note_valid  = 1'b1;
    note_period = PW'(p);
    note_dur    = DW'(d);
    forever begin
      @(negedge clk);
      acc = note_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back({PW'(p), DW'(d)});
        break;
      end
      c++;
      if (c > 3000) begin
        n_total++;
        n_bad++;
        $display("FAIL push_timeout: got no accept, want accept within 3000 cycles");
        break;
      end
    end
  endtask

  task automatic idle_inputs();
    note_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int c;
    c = 0;
    while (!(exp_q.size() == 0 && mon_left == 0 && dbg_state == ST_IDLE)) begin
      @(posedge clk);
      #1;
      c++;
      if (c > 3000) begin
        n_total++;
        n_bad++;
        $display("FAIL quiet_timeout: got still busy, want idle within 3000 cycles");
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tone", tone_out, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", note_ready, 0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    // single note: high 3 / low 3, 2 ticks
    push_note(3, 2);
    idle_inputs();
    wait_quiet();

    // fill the FIFO behind a long note; the sixth note waits for a free slot
    push_note(5, 4);
    push_note(1, 1);
    push_note(2, 1);
    push_note(3, 1);
    push_note(4, 1);
    @(negedge clk);
    chk("full_level", fifo_level, DP);
    chk("full_ready", note_ready, 0);
    push_note(5, 1);
    idle_inputs();
    wait_quiet();

    // tone, rest, tone
    push_note(2, 1);
    push_note(0, 2);
    push_note(4, 1);
    idle_inputs();
    wait_quiet();

    // zero-length note between two real notes
    push_note(3, 1);
    push_note(7, 0);
    push_note(2, 1);
    idle_inputs();
    wait_quiet();

    // reset pulse mid-note with two notes queued
    push_note(5, 3);
    push_note(2, 2);
    push_note(3, 2);
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_state", dbg_state, ST_PLAY);
    chk("pre_rst_level", fifo_level, 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", note_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    abort = 1'b1;
    @(negedge clk);
    chk("post_rst_tone", tone_out, 0);
    chk("post_rst_count", count, 0);
    chk("post_rst_level", fifo_level, 0);
    chk("post_rst_busy", busy, 0);
    repeat (20) @(posedge clk);
    #1;

`ifdef TONE_SEQ_STOP_EN
    // stop during PLAY with a push on the same edge
    push_note(3, 3);
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    note_valid  = 1'b1;
    note_period = PW'(6);
    note_dur    = DW'(1);
    stop        = 1'b1;
    @(posedge clk);
    #1;
    stop       = 1'b0;
    note_valid = 1'b0;
    exp_q.delete();
    abort = 1'b1;
    push_note(2, 1);
    idle_inputs();
    wait_quiet();
`endif

    // randomized notes with random host gaps
    for (int i = 0; i < 40; i++) begin
      push_note($urandom_range(0, 6), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        idle_inputs();
        repeat ($urandom_range(1, 12)) @(posedge clk);
        #1;
      end
    end
    idle_inputs();
    wait_quiet();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Note sequencer for the SoundStuff tone path: buffers (period, duration) note commands from a host in a small FIFO.
- Plays each note by driving an internal period counter that produces a square wave on tone_out, then automatically advances to the next note.
- Sits between the control/host logic and the audio output pin; sequences the free-running counter datapath so it needs no manual reset pulses.

Parameters:
- PERIOD_W, 8, width of note period and of the count output
- DUR_W, 8, width of note duration (in ticks)
- DEPTH, 4, FIFO depth in notes; power of 2, minimum 2
- TICK_DIV, 256, clock cycles per duration tick; minimum 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- note_valid  in  1  host presents a note
- note_period  in  PERIOD_W  half-period in clocks; 0 = rest
- note_dur  in  DUR_W  note length in ticks
- note_ready  out  1  FIFO can accept a note
- tone_out  out  1  square-wave audio output
- count  out  PERIOD_W  current period-counter value
- busy  out  1  high in LOAD or PLAY
- fifo_level  out  clog2(DEPTH)+1  notes currently queued

Behaviour:
- Reset (reset==0 at a clk edge):
  - FIFO emptied; state IDLE.
  - tone_out=0, count=0, busy=0, fifo_level=0, note_ready=0 while reset is held.
  - Applies mid-note: playback aborts immediately and all queued notes are discarded.
- Push rules:
  - A push occurs when note_valid && note_ready at a clk edge.
  - note_ready = (fifo_level < DEPTH) and not in reset; it is registered-state combinational.
  - When full, note_ready=0 even if a pop occurs the same cycle, so no push is accepted that cycle.
  - Push and pop in the same cycle (not full) leave fifo_level unchanged.
- IDLE:
  - tone_out=0, count=0, busy=0.
  - If fifo_level>0, go to LOAD next cycle.
- LOAD (exactly 1 cycle):
  - Pop the FIFO head into period_r and dur_r.
  - Clear count, the prescaler and tone_out.
  - If the popped dur==0, the note is skipped: go to LOAD again if a note remains after the pop, else IDLE.
  - Otherwise go to PLAY.
- PLAY, per clock:
  - If period_r==0 (rest): count held 0, tone_out held 0.
  - Else: if count==period_r-1, count<=0 and tone_out toggles; otherwise count<=count+1.
  - Full waveform period = 2*period_r clocks.
  - Prescaler counts 0..TICK_DIV-1; a tick is presc==TICK_DIV-1. On a tick, dur_r decrements.
  - Note ends on the edge where tick && dur_r==1. Next state: LOAD if fifo_level>0 (counting any push that same cycle), else IDLE.
  - tone_out and count are cleared on that edge.
  - Note occupies exactly dur*TICK_DIV PLAY cycles; note-to-note gap is the single LOAD cycle.
- Widths: count never exceeds period_r-1. All counters wrap only as described; no overflow paths.

Optional Feature:
- Macro: TONE_SEQ_STOP_EN.
- Defined: adds input port stop (1 bit, after note_dur). stop==1 at a clk edge behaves like reset for the FIFO, state and outputs, except note_ready may be 1 that same cycle; a simultaneous push is discarded. reset still has priority over stop.
- Undefined: no stop port; only reset aborts playback.

Test Plan (bench uses TICK_DIV=4, DEPTH=4):
- Reset, then push (period=3, dur=2) -> LOAD 1 cycle after push; tone_out toggles every 3 clocks (high 3, low 3); busy high for 1+8 cycles; returns IDLE with tone_out=0, count=0.
- Push 5 notes back-to-back with no playback progress -> note_ready falls after 4th accepted (fifo_level=4); 5th held until first LOAD pops, then accepted the cycle after.
- Sequence (2,1),(0,2),(4,1) -> tone 4 clks/cycle for 4 clks, rest (tone_out=0, count=0) for 8 clks, then toggles every 4 clks; single LOAD cycle between each.
- Note with dur=0 between two valid notes -> consumes one LOAD cycle, no PLAY; following note starts next cycle.
- Assert reset=0 for 1 cycle mid-note with 2 notes queued -> next cycle tone_out=0, count=0, fifo_level=0, busy=0; nothing plays afterward.
- With TONE_SEQ_STOP_EN: stop=1 for 1 cycle during PLAY with note_valid high -> FIFO empty, IDLE, pushed note dropped; a new push next cycle plays normally.
